mmio_io_ports: RTL and testbench
================================

# mmio_io_ports

Parametrised memory-mapped board-I/O block for the MIPS processor. It replaces the fixed two-button, ten-switch, six-digit I/O with a generalised controller that adds:
- configurable switch width, button count and digit count;
- per-button debouncing, with sticky press flags that clear on read;
- per-digit blanking;
- a registered one-cycle read path that matches the data RAM.

It sits on the processor's data-memory bus beside the RAM. The address decoder asserts `sel` for the I/O window.

## Interface
Parameters:
- `SW_WIDTH`, default 10: switch inputs; must be ≤ 32.
- `NUM_BUTTONS`, default 2: push buttons; must be ≤ 8.
- `NUM_INPORTS`, default 2: latched input ports; must be ≤ `NUM_BUTTONS`. Button k loads inport k.
- `NUM_DIGITS`, default 6: seven-segment digits; must be ≤ 8.
- `DEBOUNCE_CYCLES`, default 4: stable-sample count; must be ≥ 1.
- `BTN_ACTIVE_LOW`, default 1: when 1, a raw button at 0 means pressed.

Ports:
- `clk` in 1: single clock. Every register updates on its rising edge.
- `rst` in 1: reset, synchronous and active-low. `rst`=0 at a rising edge resets the block.
- `buttons` in `NUM_BUTTONS`: raw, asynchronous.
- `switches` in `SW_WIDTH`: raw, asynchronous.
- `sel` in 1: the bus access targets this block.
- `addr` in 3: word index inside the window.
- `wr_en` in 1: write strobe, qualified by `sel`.
- `rd_en` in 1: read strobe, qualified by `sel`.
- `wdata` in 32: write data.
- `rdata` out 32: read data, registered.
- `rd_valid` out 1: `rdata` is valid this cycle.
- `LEDs` out 7×`NUM_DIGITS`: active-low segments {g..a}. Digit 0 occupies bits [6:0].

## Operation
Register map (`addr`):
- 0 OUTPORT (R/W): 32-bit value shown as hex. Digit d shows nibble d.
- 1…`NUM_INPORTS`: INPORTk-1 (RO): the switch value latched on a press of button k-1, zero-extended.
- 5 STATUS (RO, read-clear): bit k is the sticky press flag for button k. Bits [31:8] read 0.
- 6 BLANK (R/W): bits [`NUM_DIGITS`-1:0]; bit d=1 blanks digit d. Other bits are ignored on write and read as 0.
- Any other index reads 0. Writes to read-only or unmapped indices are ignored.

Input path:
- Switches pass through a 2-flop synchroniser.
- Each button passes through a 2-flop synchroniser, then a debouncer.
- The debounced level flips after the synchronised level has differed from it for `DEBOUNCE_CYCLES` consecutive samples. Any sample equal to the current level resets the counter.
- A press event is one cycle on the debounced transition to the pressed level. Releases generate no event.

On a press event for button k:
- STATUS[k] is set.
- If k < `NUM_INPORTS`, INPORTk is loaded with the synchronised switches in the same cycle.

Display:
- Each unblanked digit shows the hex glyph of its nibble, 0–F.
- Each blanked digit drives 7'h7F (all segments off).

Boundary rules:
- A press event and a STATUS read in the same cycle: the set wins. `rdata` returns the pre-event value, and the bit stays 1.
- Reset with a bounce in progress: debounce counters clear to 0, and the debounced level becomes the released level. No event is generated.
- `wr_en` and `rd_en` both high: the write is performed. The read returns the old contents.
- `rd_en` or `wr_en` with `sel`=0: no effect.

## Timing
Reset values:
- OUTPORT=0, BLANK=0, INPORTs=0, STATUS=0.
- `rdata`=0, `rd_valid`=0.
- `LEDs` = `NUM_DIGITS` copies of 7'b1000000, i.e. every digit shows "0".

Read:
- A read sampled at edge N has `rdata`/`rd_valid` valid after edge N, for exactly one cycle.
- `rdata` holds its value while `rd_valid`=0.

Write:
- A write sampled at edge N takes effect after edge N.
- `LEDs` reflect the new value after edge N+1, because the segment outputs are registered.

Press latency:
- A raw level change first sampled at edge 0 that stays stable gives STATUS/INPORT updated after edge `DEBOUNCE_CYCLES`+2.
- This is 2 edges of synchroniser plus `DEBOUNCE_CYCLES` of count.

## Structure
Package `mmio_io_pkg` holds:
- the register index constants;
- the `seg7_t` typedef;
- the hex-to-segment function with the glyph table;
- the blank constant 7'h7F.

Sub-module `button_debouncer`, parametrised by `DEBOUNCE_CYCLES`, is instantiated once per button. It takes the synchronised input and produces the debounced level plus the press pulse.

The top level holds the register file, read mux, sticky logic and segment output registers.

## Test plan
- **Reset:** `rst`=0 for 2 cycles → `LEDs`=42'h… with every digit 7'b1000000, `rd_valid`=0. Reading STATUS returns 0.
- **OUTPORT and BLANK:** write OUTPORT 32'h00A5_3F01.
  - Digits 0..5 show 1,0,F,3,5,A (digit 0 = 7'b1111001) two edges after the write.
  - Then write BLANK=6'b100000 → digit 5 = 7'h7F.
- **Debounced load:** `switches`=10'h2AB, then press button1 (raw 0) and hold 10 cycles.
  - INPORT1 = 32'h0000_02AB after edge `DEBOUNCE_CYCLES`+2.
  - STATUS = 2'b10 on first read, 0 on the next read.
- **Bounce rejection:** toggle button0 every 2 cycles for 20 cycles with `DEBOUNCE_CYCLES`=4 → INPORT0 unchanged and STATUS = 0.
- **Simultaneous set and clear:** a STATUS read in the same cycle as a button0 press event → `rdata`=0, and the following read returns 1.
- **Reset mid-debounce:** pulse `rst`=0 after 2 stable samples of a press, then hold the press → the event arrives `DEBOUNCE_CYCLES`+2 edges after reset deasserts.

Source files
------------

// File: rtl/mmio_io_pkg.sv
// Shared definitions for the memory-mapped board I/O block: register indices,
// the seven-segment type and the hex glyph table used by the display path.
package mmio_io_pkg;

   localparam logic [2:0] ADDR_OUTPORT     = 3'd0;
   localparam logic [2:0] ADDR_INPORT_BASE = 3'd1;
   localparam logic [2:0] ADDR_STATUS      = 3'd5;
   localparam logic [2:0] ADDR_BLANK       = 3'd6;

   // Only indices 1..4 sit between OUTPORT and STATUS, so at most four inports are addressable.
   localparam int MAX_INPORTS = 4;

   typedef logic [6:0] seg7_t;

   localparam seg7_t SEG_BLANK = 7'h7F;

   // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
   function automatic seg7_t hexToSeg(input logic [3:0] nibble);
      seg7_t seg;
      case (nibble)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// Debounces one already-synchronised button. The input is normalised so that
// 1 means pressed; the debounced level starts released and a one-cycle press
// pulse is produced on each debounced transition into the pressed level.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic sampled,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] count;
   logic          level;

   // Count consecutive samples that disagree with the current level; any agreeing sample restarts the count, and the level flips on the last disagreeing sample.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
         level <= 1'b0;
         press <= 1'b0;
      end else begin
         press <= 1'b0;
         if (sampled == level) begin
            count <= '0;
         end else if (count == LAST_COUNT) begin
            count <= '0;
            level <= sampled;
            press <= sampled;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mmio_io_ports.sv
// Parametrised memory-mapped board I/O for the MIPS data bus: a hex display
// port with per-digit blanking, debounced buttons with sticky read-clear flags,
// button-latched switch inports and a registered one-cycle read path.
module mmio_io_ports
   import mmio_io_pkg::*;
#(
   parameter int SW_WIDTH        = 10,
   parameter int NUM_BUTTONS     = 2,
   parameter int NUM_INPORTS     = 2,
   parameter int NUM_DIGITS      = 6,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int BTN_ACTIVE_LOW  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_BUTTONS-1:0]  buttons,
   input  logic [SW_WIDTH-1:0]     switches,
   input  logic                    sel,
   input  logic [2:0]              addr,
   input  logic                    wr_en,
   input  logic                    rd_en,
   input  logic [31:0]             wdata,
   output logic [31:0]             rdata,
   output logic                    rd_valid,
   output logic [7*NUM_DIGITS-1:0] LEDs
);

   localparam logic [NUM_BUTTONS-1:0] BTN_IDLE = (BTN_ACTIVE_LOW != 0) ? '1 : '0;

   logic [SW_WIDTH-1:0]    swMeta;
   logic [SW_WIDTH-1:0]    swSync;
   logic [NUM_BUTTONS-1:0] btnMeta;
   logic [NUM_BUTTONS-1:0] btnSync;
   logic [NUM_BUTTONS-1:0] btnPressed;
   logic [NUM_BUTTONS-1:0] pressEvent;

   logic [31:0]            outport;
   logic [NUM_DIGITS-1:0]  blank;
   logic [SW_WIDTH-1:0]    inport [NUM_INPORTS];
   logic [NUM_BUTTONS-1:0] status;

   logic                   busRead;
   logic                   busWrite;
   logic                   statusRead;
   logic [31:0]            readMux;

   assign busRead    = sel & rd_en;
   assign busWrite   = sel & wr_en;
   assign statusRead = busRead && (addr == ADDR_STATUS);

   // Buttons reset to their idle (released) raw level so a held button after reset is seen as a fresh change.
   always_ff @(posedge clk) begin
      if (!rst) begin
         swMeta  <= '0;
         swSync  <= '0;
         btnMeta <= BTN_IDLE;
         btnSync <= BTN_IDLE;
      end else begin
         swMeta  <= switches;
         swSync  <= swMeta;
         btnMeta <= buttons;
         btnSync <= btnMeta;
      end
   end

   assign btnPressed = btnSync ^ BTN_IDLE;

   for (genvar k = 0; k < NUM_BUTTONS; k++) begin : g_debounce
      button_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debouncer (
         .clk    (clk),
         .rst    (rst),
         .sampled(btnPressed[k]),
         .press  (pressEvent[k])
      );
   end

   // Register file: bus writes to OUTPORT/BLANK, press-driven inport loads, and sticky flags where a new press beats a same-cycle read-clear.
   always_ff @(posedge clk) begin
      if (!rst) begin
         outport <= '0;
         blank   <= '0;
         status  <= '0;
         for (int k = 0; k < NUM_INPORTS; k++) begin
            inport[k] <= '0;
         end
      end else begin
         if (busWrite && (addr == ADDR_OUTPORT)) begin
            outport <= wdata;
         end
         if (busWrite && (addr == ADDR_BLANK)) begin
            blank <= wdata[NUM_DIGITS-1:0];
         end
         status <= (statusRead ? '0 : status) | pressEvent;
         for (int k = 0; k < NUM_INPORTS; k++) begin
            if (pressEvent[k]) begin
               inport[k] <= swSync;
            end
         end
      end
   end

   // Read mux over the current register contents; unmapped indices return zero.
   always_comb begin
      readMux = '0;
      case (addr)
         ADDR_OUTPORT: readMux = outport;
         ADDR_STATUS:  readMux = 32'(status);
         ADDR_BLANK:   readMux = 32'(blank);
         default: begin
            for (int k = 0; k < NUM_INPORTS; k++) begin
               if ((k < MAX_INPORTS) && (addr == ADDR_INPORT_BASE + 3'(k))) begin
                  readMux = 32'(inport[k]);
               end
            end
         end
      endcase
   end

   // Registered read port: data appears one edge after the request and holds until the next read.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rdata    <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= busRead;
         if (busRead) begin
            rdata <= readMux;
         end
      end
   end

   // Segment outputs are registered from OUTPORT and BLANK, so they trail a write by one more edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int d = 0; d < NUM_DIGITS; d++) begin
            LEDs[7*d +: 7] <= hexToSeg(4'h0);
         end
      end else begin
         for (int d = 0; d < NUM_DIGITS; d++) begin
            LEDs[7*d +: 7] <= blank[d] ? SEG_BLANK : hexToSeg(outport[4*d +: 4]);
         end
      end
   end

endmodule

// File: tb/tb_mmio_io_ports.sv
// Directed bench for mmio_io_ports with default parameters. Reads push their
// hand-computed expected data into a queue; a monitor pops and compares each
// time rd_valid is seen. Display and reset-state checks are made directly.
module tb_mmio_io_ports;

   localparam int DC = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  buttons;
   logic [9:0]  switches;
   logic        sel;
   logic [2:0]  addr;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        rd_valid;
   logic [41:0] LEDs;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] expQ[$];
   string       nameQ[$];
   logic [31:0] monExp;
   string       monName;

   localparam logic [41:0] LED_ZEROS   = {6{7'h40}};
   localparam logic [41:0] LED_PATTERN = {7'h08, 7'h12, 7'h30, 7'h0E, 7'h40, 7'h79};
   localparam logic [41:0] LED_BLANK5  = {7'h7F, 7'h12, 7'h30, 7'h0E, 7'h40, 7'h79};

   mmio_io_ports dut (
      .clk     (clk),
      .rst     (rst),
      .buttons (buttons),
      .switches(switches),
      .sel     (sel),
      .addr    (addr),
      .wr_en   (wr_en),
      .rd_en   (rd_en),
      .wdata   (wdata),
      .rdata   (rdata),
      .rd_valid(rd_valid),
      .LEDs    (LEDs)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   task automatic checkOutput(input string nm, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", nm, actual, expected);
      end
   endtask

   // One bus cycle, started at a falling edge and ending at the next one.
   task automatic applyStimulus(input logic w, input logic r, input logic [2:0] a, input logic [31:0] d);
      sel   = 1'b1;
      wr_en = w;
      rd_en = r;
      addr  = a;
      wdata = d;
      @(negedge clk);
      sel   = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic busRead(input logic [2:0] a, input logic [31:0] exp, input string nm);
      expQ.push_back(exp);
      nameQ.push_back(nm);
      applyStimulus(1'b0, 1'b1, a, 32'h0);
   endtask

   task automatic busWrite(input logic [2:0] a, input logic [31:0] d);
      applyStimulus(1'b1, 1'b0, a, d);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: every cycle with rd_valid must match the oldest outstanding expected read.
   always @(negedge clk) begin
      if (rd_valid === 1'b1) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_rd_valid: got rdata %h expected no read pending", rdata);
         end else begin
            monExp  = expQ.pop_front();
            monName = nameQ.pop_front();
            checkOutput(monName, 64'(rdata), 64'(monExp));
         end
      end
   end

   // Safety net so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus sequence.
   initial begin
      rst      = 1'b0;
      buttons  = 2'b11;
      switches = 10'h000;
      sel      = 1'b0;
      addr     = 3'd0;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      wdata    = 32'h0;
      $display("[TB] reset");
      idle(2);
      checkOutput("reset_LEDs", 64'(LEDs), 64'(LED_ZEROS));
      checkOutput("reset_rd_valid", 64'(rd_valid), 64'd0);
      checkOutput("reset_rdata", 64'(rdata), 64'd0);
      rst = 1'b1;
      busRead(3'd5, 32'd0, "reset_STATUS");
      busRead(3'd0, 32'd0, "reset_OUTPORT");
      busRead(3'd1, 32'd0, "reset_INPORT0");
      busRead(3'd6, 32'd0, "reset_BLANK");

      $display("[TB] outport and blank");
      busWrite(3'd0, 32'h00A5_3F01);
      checkOutput("LEDs_one_edge_after_write", 64'(LEDs), 64'(LED_ZEROS));
      idle(1);
      checkOutput("LEDs_two_edges_after_write", 64'(LEDs), 64'(LED_PATTERN));
      busRead(3'd0, 32'h00A5_3F01, "OUTPORT_readback");
      busWrite(3'd6, 32'hFFFF_FFE0);
      idle(1);
      checkOutput("LEDs_digit5_blanked", 64'(LEDs), 64'(LED_BLANK5));
      busRead(3'd6, 32'h0000_0020, "BLANK_masked_readback");

      sel   = 1'b0;
      wr_en = 1'b1;
      rd_en = 1'b1;
      addr  = 3'd0;
      wdata = 32'hDEAD_BEEF;
      idle(1);
      wr_en = 1'b0;
      rd_en = 1'b0;
      checkOutput("no_rd_valid_without_sel", 64'(rd_valid), 64'd0);
      busWrite(3'd5, 32'h0000_00FF);
      busRead(3'd5, 32'd0, "STATUS_ignores_write");
      busRead(3'd0, 32'h00A5_3F01, "OUTPORT_ignores_unselected_write");
      expQ.push_back(32'h00A5_3F01);
      nameQ.push_back("wr_rd_returns_old");
      applyStimulus(1'b1, 1'b1, 3'd0, 32'h1234_5678);
      busRead(3'd0, 32'h1234_5678, "OUTPORT_after_wr_rd");
      busRead(3'd7, 32'd0, "unmapped_7");
      busRead(3'd3, 32'd0, "unmapped_inport2");

      $display("[TB] debounced load");
      switches = 10'h2AB;
      idle(4);
      buttons = 2'b01;
      idle(DC + 2);
      busRead(3'd2, 32'd0, "INPORT1_on_event_edge");
      busRead(3'd2, 32'h0000_02AB, "INPORT1_loaded");
      busRead(3'd5, 32'd2, "STATUS_first_read");
      busRead(3'd5, 32'd0, "STATUS_cleared");
      busRead(3'd1, 32'd0, "INPORT0_untouched");
      buttons = 2'b11;
      idle(DC + 6);
      busRead(3'd5, 32'd0, "no_release_event");

      $display("[TB] bounce rejection");
      switches = 10'h155;
      idle(4);
      for (int i = 0; i < 10; i++) begin
         buttons[0] = ~buttons[0];
         idle(2);
      end
      idle(DC + 6);
      busRead(3'd1, 32'd0, "INPORT0_after_bounce");
      busRead(3'd5, 32'd0, "STATUS_after_bounce");

      $display("[TB] simultaneous set and clear");
      buttons = 2'b10;
      idle(DC + 2);
      busRead(3'd5, 32'd0, "STATUS_read_on_event_edge");
      busRead(3'd5, 32'd1, "STATUS_kept_by_set");
      busRead(3'd5, 32'd0, "STATUS_cleared_after");
      busRead(3'd1, 32'h0000_0155, "INPORT0_loaded");
      busRead(3'd2, 32'h0000_02AB, "INPORT1_retained");
      buttons = 2'b11;
      idle(DC + 6);

      $display("[TB] reset mid-debounce");
      buttons = 2'b01;
      idle(2);
      rst = 1'b0;
      idle(1);
      checkOutput("reset_clears_rdata", 64'(rdata), 64'd0);
      checkOutput("reset_clears_rd_valid", 64'(rd_valid), 64'd0);
      checkOutput("reset_restores_LEDs", 64'(LEDs), 64'(LED_ZEROS));
      rst = 1'b1;
      idle(DC + 1);
      busRead(3'd5, 32'd0, "STATUS_before_event_after_reset");
      busRead(3'd5, 32'd0, "STATUS_on_event_edge_after_reset");
      busRead(3'd5, 32'd2, "STATUS_event_after_reset");
      busRead(3'd2, 32'h0000_0155, "INPORT1_reload_after_reset");
      busRead(3'd0, 32'd0, "OUTPORT_after_reset");
      buttons = 2'b11;
      idle(4);
      checkOutput("read_queue_drained", 64'(expQ.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
